// File: rtl/mvm_param_pkg.sv
// mvm_param shared state type, accumulator sizing and output conversion.
// Define MVM_PARAM_SAT_EN for saturating output; default wraps.
package mvm_param_pkg;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        OUTPUT
    } state_t;

    function automatic int acc_width(input int n, input int in_w);
        return 2 * in_w + $clog2(n) + 1;
    endfunction

    // Result is sign-correct in its low out_w bits; callers truncate.
    function automatic logic signed [63:0] sat_trunc(
        input logic signed [63:0] acc,
        input int                 out_w
    );
`ifdef MVM_PARAM_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (acc > hi) return hi;
        if (acc < lo) return lo;
        return acc;
`else
        return (acc <<< (64 - out_w)) >>> (64 - out_w);
`endif
    endfunction

endpackage

// File: rtl/mvm_param_mac.sv
// mvm_param registered signed multiply-accumulate.
// load_init seeds acc with the bias; en adds one product.
module mvm_param_mac
    import mvm_param_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int ACC_W = acc_width(4, 8)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_init,
    input  logic                    en,
    input  logic signed [ACC_W-1:0] init,
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*IN_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;

    assign prod     = a * b;
    assign prod_ext = $signed({{(ACC_W-2*IN_W){prod[2*IN_W-1]}}, prod});

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (load_init) begin
            acc <= init;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/mvm_param.sv
// mvm_param: serial-stream y = W*x + b engine, NxN signed.
// MVM_PARAM_SAT_EN (see package) selects saturating output.
module mvm_param
    import mvm_param_pkg::*;
#(
    parameter int N       = 4,
    parameter int IN_W    = 8,
    parameter int OUT_W   = 16,
    parameter int REUSE_W = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    input  logic                    m_ready,
    input  logic signed [IN_W-1:0]  data_in,
    output logic                    m_valid,
    output logic                    s_ready,
    output logic signed [OUT_W-1:0] data_out
);

    localparam int ACC_W = acc_width(N, IN_W);
    localparam int NW    = N * N;
    localparam int NT    = NW + 2 * N;
    localparam int CW    = $clog2(NT);
    localparam int AW    = $clog2(NW);
    localparam int RW    = $clog2(N);
    localparam int PW    = $clog2(N + 2);

    localparam logic [CW-1:0] LAST_WORD = CW'(NT - 1);
    localparam logic [CW-1:0] X_BASE    = CW'(NW);
    localparam logic [RW-1:0] LAST_ROW  = RW'(N - 1);
    localparam logic [PW-1:0] MAC_END   = PW'(N);

    logic signed [IN_W-1:0] w_mem [NW];
    logic signed [IN_W-1:0] x_mem [N];
    logic signed [IN_W-1:0] b_mem [N];

    state_t           state, state_n;
    logic [CW-1:0]    wr_cnt, wr_cnt_n;
    logic             w_loaded, w_loaded_n;
    logic [RW-1:0]    row, row_n;
    logic [PW-1:0]    phase, phase_n;
    logic [RW-1:0]    kx, kx_n;
    logic [AW-1:0]    w_ptr, w_ptr_n;
    logic             s_ready_n, m_valid_n;
    logic signed [OUT_W-1:0] data_out_n;
    logic             wr_en, load_init, mac_en;
    logic signed [ACC_W-1:0] acc, bias_ext;
    logic signed [63:0]      acc_wide;

    assign bias_ext = $signed({{(ACC_W-IN_W){b_mem[row][IN_W-1]}},
                               b_mem[row]});
    assign acc_wide = $signed({{(64-ACC_W){acc[ACC_W-1]}}, acc});

    mvm_param_mac #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk       (clk),
        .reset     (reset),
        .load_init (load_init),
        .en        (mac_en),
        .init      (bias_ext),
        .a         (w_mem[w_ptr]),
        .b         (x_mem[kx]),
        .acc       (acc)
    );

    // Operand store: decoded by the running word count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NW; i++) begin
                if (wr_cnt == CW'(i)) w_mem[i] <= data_in;
            end
            for (int i = 0; i < N; i++) begin
                if (wr_cnt == CW'(NW + i)) x_mem[i] <= data_in;
                if (wr_cnt == CW'(NW + N + i)) b_mem[i] <= data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LOAD;
            wr_cnt   <= '0;
            w_loaded <= 1'b0;
            row      <= '0;
            phase    <= '0;
            kx       <= '0;
            w_ptr    <= '0;
            s_ready  <= 1'b0;
            m_valid  <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_n;
            wr_cnt   <= wr_cnt_n;
            w_loaded <= w_loaded_n;
            row      <= row_n;
            phase    <= phase_n;
            kx       <= kx_n;
            w_ptr    <= w_ptr_n;
            s_ready  <= s_ready_n;
            m_valid  <= m_valid_n;
            data_out <= data_out_n;
        end
    end

    always_comb begin
        state_n    = state;
        wr_cnt_n   = wr_cnt;
        w_loaded_n = w_loaded;
        row_n      = row;
        phase_n    = phase;
        kx_n       = kx;
        w_ptr_n    = w_ptr;
        m_valid_n  = m_valid;
        data_out_n = data_out;
        wr_en      = 1'b0;
        load_init  = 1'b0;
        mac_en     = 1'b0;

        unique case (state)
            LOAD: begin
                if (s_valid && s_ready) begin
                    wr_en = 1'b1;
                    if (wr_cnt == LAST_WORD) begin
                        state_n    = COMPUTE;
                        w_loaded_n = 1'b1;
                        row_n      = '0;
                        phase_n    = '0;
                        w_ptr_n    = '0;
                    end else begin
                        wr_cnt_n = wr_cnt + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                // phase 0 seeds bias, 1..N accumulate, N+1 emits.
                if (phase == '0) begin
                    load_init = 1'b1;
                    kx_n      = '0;
                    phase_n   = phase + 1'b1;
                end else if (phase <= MAC_END) begin
                    mac_en  = 1'b1;
                    kx_n    = kx + 1'b1;
                    w_ptr_n = w_ptr + 1'b1;
                    phase_n = phase + 1'b1;
                end else begin
                    data_out_n = OUT_W'(sat_trunc(acc_wide, OUT_W));
                    m_valid_n  = 1'b1;
                    state_n    = OUTPUT;
                end
            end
            OUTPUT: begin
                if (m_ready) begin
                    m_valid_n = 1'b0;
                    if (row != LAST_ROW) begin
                        row_n   = row + 1'b1;
                        phase_n = '0;
                        state_n = COMPUTE;
                    end else begin
                        state_n  = LOAD;
                        wr_cnt_n = ((REUSE_W != 0) && w_loaded)
                                   ? X_BASE : '0;
                    end
                end
            end
            default: state_n = LOAD;
        endcase

        s_ready_n = (state_n == LOAD);
    end

endmodule

// File: tb/tb_mvm_param.sv
// Randomised bench for mvm_param against a plain-arithmetic model.
// Instance 0 reloads W every time; instance 1 has REUSE_W=1.
module tb_mvm_param;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sel = 1'b0;
    logic s_valid = 1'b0;
    logic m_ready = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic sr0, mv0, sr1, mv1;
    logic [15:0] do0, do1;
    logic s_ready, m_valid;
    logic [15:0] data_out;

    int checks = 0;
    int errors = 0;

    int wm [N*N];
    int xm [N];
    int bm [N];

    assign s_ready  = sel ? sr1 : sr0;
    assign m_valid  = sel ? mv1 : mv0;
    assign data_out = sel ? do1 : do0;

    always #5 clk = ~clk;

    mvm_param #(
        .N(N), .IN_W(8), .OUT_W(16), .REUSE_W(0)
    ) dut0 (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (s_valid & ~sel),
        .m_ready  (m_ready & ~sel),
        .data_in  (data_in),
        .m_valid  (mv0),
        .s_ready  (sr0),
        .data_out (do0)
    );

    mvm_param #(
        .N(N), .IN_W(8), .OUT_W(16), .REUSE_W(1)
    ) dut1 (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (s_valid & sel),
        .m_ready  (m_ready & sel),
        .data_in  (data_in),
        .m_valid  (mv1),
        .s_ready  (sr1),
        .data_out (do1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] conv(input longint a);
        logic [63:0] t;
`ifdef MVM_PARAM_SAT_EN
        if (a > 32767) return 16'h7fff;
        if (a < -32768) return 16'h8000;
`endif
        t = a;
        return t[15:0];
    endfunction

    // One word; random idle gaps carry garbage with s_valid low.
    task automatic put(input int w);
        int  t;
        logic acc;
        t = 0;
        while ($urandom_range(0, 2) == 0) begin
            s_valid = 1'b0;
            data_in = 8'($urandom);
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        data_in = 8'(w);
        forever begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk); #1;
            if (acc) break;
            t++;
            if (t > 100) begin
                check("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        s_valid = 1'b0;
        data_in = 8'($urandom);
    endtask

    task automatic send_words(input bit full);
        if (full) for (int i = 0; i < N*N; i++) put(wm[i]);
        for (int i = 0; i < N; i++) put(xm[i]);
        for (int i = 0; i < N; i++) put(bm[i]);
    endtask

    task automatic run_txn(input bit full, input bit hold10);
        logic [15:0] exp_y [N];
        longint acc;
        int lat;
        int h;
        for (int r = 0; r < N; r++) begin
            acc = bm[r];
            for (int k = 0; k < N; k++)
                acc += longint'(wm[r*N+k]) * longint'(xm[k]);
            exp_y[r] = conv(acc);
        end
        m_ready = 1'($urandom_range(0, 1));
        send_words(full);
        for (int r = 0; r < N; r++) begin
            lat = 0;
            while (!m_valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            check("latency", 32'(lat), 32'(N + 2));
            check("y", {16'h0, data_out}, {16'h0, exp_y[r]});
            h = (r == 0 && hold10) ? 10 : int'($urandom_range(0, 3));
            if (h > 0) begin
                m_ready = 1'b0;
                repeat (h) begin
                    @(posedge clk); #1;
                    check("hold_y", {16'h0, data_out}, {16'h0, exp_y[r]});
                    check("hold_v", {31'h0, m_valid}, 32'd1);
                end
            end
            m_ready = 1'b1;
            @(posedge clk); #1;
            check("v_drop", {31'h0, m_valid}, 32'd0);
            m_ready = 1'($urandom_range(0, 1));
        end
        check("s_ready_back", {31'h0, s_ready}, 32'd1);
    endtask

    task automatic set_identity();
        for (int i = 0; i < N*N; i++) wm[i] = (i / N == i % N) ? 1 : 0;
    endtask

    task automatic randomize_all(input bit with_w);
        if (with_w)
            for (int i = 0; i < N*N; i++)
                wm[i] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < N; i++) begin
            xm[i] = int'($urandom_range(0, 255)) - 128;
            bm[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_sr0", {31'h0, sr0}, 32'd0);
        check("rst_mv0", {31'h0, mv0}, 32'd0);
        check("rst_do0", {16'h0, do0}, 32'd0);
        check("rst_sr1", {31'h0, sr1}, 32'd0);
        check("rst_mv1", {31'h0, mv1}, 32'd0);
        check("rst_do1", {16'h0, do1}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("sr0_rise", {31'h0, sr0}, 32'd1);
        check("sr1_rise", {31'h0, sr1}, 32'd1);

        sel = 1'b0;
        set_identity();
        xm = '{1, 2, 3, 4};
        bm = '{0, 0, 0, 0};
        run_txn(1'b1, 1'b0);

        for (int i = 0; i < N*N; i++) wm[i] = 2;
        xm = '{1, -1, 3, -3};
        bm = '{10, -10, 0, 5};
        run_txn(1'b1, 1'b0);

        for (int i = 0; i < N*N; i++) wm[i] = 127;
        xm = '{127, 127, 127, 127};
        bm = '{127, 127, 127, 127};
        run_txn(1'b1, 1'b0);

        for (int i = 0; i < N*N; i++) wm[i] = -128;
        bm = '{-128, -128, -128, -128};
        run_txn(1'b1, 1'b0);

        for (int t = 0; t < 5; t++) begin
            randomize_all(1'b1);
            run_txn(1'b1, t == 0);
        end

        sel = 1'b1;
        set_identity();
        xm = '{1, 2, 3, 4};
        bm = '{0, 0, 0, 0};
        run_txn(1'b1, 1'b0);
        xm = '{5, 6, 7, 8};
        run_txn(1'b0, 1'b0);
        randomize_all(1'b0);
        run_txn(1'b0, 1'b0);

        randomize_all(1'b0);
        send_words(1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_sr", {31'h0, sr1}, 32'd0);
        check("mid_rst_mv", {31'h0, mv1}, 32'd0);
        check("mid_rst_do", {16'h0, do1}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_sr_rise", {31'h0, sr1}, 32'd1);

        randomize_all(1'b1);
        run_txn(1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
